// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scan-capable register file.
// Imported by the interface, the dump FSM and the top.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/regfile_scan_if.sv
// Datapath ports plus the valid/ready dump channel of regfile_scan.
// master = datapath/consumer side, slave = register file.
interface regfile_scan_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [AW-1:0]    dump_addr;
  logic [WIDTH-1:0] dump_data;
  logic             dump_busy;
  logic             dump_done;

  modport master (
    output we, wa, wd, ra1, ra2,
    output dump_start, dump_ready,
    input  rd1, rd2,
    input  dump_valid, dump_addr, dump_data,
    input  dump_busy, dump_done
  );

  modport slave (
    input  we, wa, wd, ra1, ra2,
    input  dump_start, dump_ready,
    output rd1, rd2,
    output dump_valid, dump_addr, dump_data,
    output dump_busy, dump_done
  );

endinterface

// File: rtl/regfile_dump_fsm.sv
// Scan engine: walks every register out over valid/ready,
// capturing each beat with forwarding from a same-edge write.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       ready_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wa_i,
  input  logic [WIDTH-1:0]           wd_i,
  input  logic [WIDTH-1:0]           rdata_i,
  output logic [$clog2(DEPTH)-1:0]   ld_addr_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH)-1:0]   addr_o,
  output logic [WIDTH-1:0]           data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] beat;

  // Address the next beat would load from on this edge.
  assign ld_addr_o = (state_q == SCAN) ? addr_q + 1'b1 : '0;
  assign beat = (wr_en_i && wa_i == ld_addr_o) ? wd_i : rdata_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
          addr_d  = '0;
          data_d  = beat;
        end
      end
      SCAN: begin
        if (ready_i) begin
          if (addr_q == LAST) begin
            state_d = DONE;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            addr_d = ld_addr_o;
            data_d = beat;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid_o = (state_q == SCAN);
  assign busy_o  = (state_q == SCAN);
  assign done_o  = (state_q == DONE);
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_scan.sv
// Register file, two async read ports, one write port,
// plus a synthesizable dump engine for debug readout.
module regfile_scan
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b1
) (
  input logic          clk,
  input logic          reset,
  regfile_scan_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_rdata;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < LIM;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] rd_port(
    input logic [AW-1:0] a
  );
    if (!in_range(a) || is_zero(a)) return '0;
    return mem_q[a];
  endfunction

  assign wr_en = bus.we && in_range(bus.wa) && !is_zero(bus.wa);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  assign bus.rd1 = rd_port(bus.ra1);
  assign bus.rd2 = rd_port(bus.ra2);

  // Register 0 is never written when hardwired, so it reads 0 here.
  assign ld_rdata = mem_q[ld_addr];

  regfile_dump_fsm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.dump_start),
    .ready_i   (bus.dump_ready),
    .wr_en_i   (wr_en),
    .wa_i      (bus.wa),
    .wd_i      (bus.wd),
    .rdata_i   (ld_rdata),
    .ld_addr_o (ld_addr),
    .valid_o   (bus.dump_valid),
    .busy_o    (bus.dump_busy),
    .done_o    (bus.dump_done),
    .addr_o    (bus.dump_addr),
    .data_o    (bus.dump_data)
  );

endmodule

// File: tb/tb_regfile_scan.sv
// Scoreboard bench for regfile_scan: three configurations,
// reference model arrays, queued expected dump beats.
module tb_regfile_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scan_if #(.WIDTH(32), .DEPTH(32)) ifa ();
  regfile_scan_if #(.WIDTH(16), .DEPTH(8))  ifb ();
  regfile_scan_if #(.WIDTH(8),  .DEPTH(5))  ifc ();

  regfile_scan #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(rst_n), .bus(ifa.slave));
  regfile_scan #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(rst_n), .bus(ifb.slave));
  regfile_scan #(.WIDTH(8), .DEPTH(5), .ZERO_REG(0)) u_c (
    .clk(clk), .reset(rst_n), .bus(ifc.slave));

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  bit    done_pend_a = 0;
  bit    done_pend_b = 0;

  logic [31:0] ma [32];
  logic [15:0] mb [8];
  logic [7:0]  mc [5];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample mid-cycle; a handshake happens on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_pend_a) begin
        chk("A done pulse", {31'b0, ifa.dump_done}, 32'd1);
        chk("A valid after last", {31'b0, ifa.dump_valid}, 32'd0);
        done_pend_a = 0;
      end else begin
        chk("A done idle", {31'b0, ifa.dump_done}, 32'd0);
      end
      if (ifa.dump_valid) begin
        chk("A busy", {31'b0, ifa.dump_busy}, 32'd1);
        if (qa.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL A unexpected beat: got addr %0d want none",
                   ifa.dump_addr);
        end else if (ifa.dump_ready) begin
          beat_t e;
          e = qa.pop_front();
          chk("A beat addr", 32'(ifa.dump_addr), 32'(e.addr));
          chk("A beat data", ifa.dump_data, e.data);
          if (e.last) done_pend_a = 1;
        end else begin
          chk("A held addr", 32'(ifa.dump_addr), 32'(qa[0].addr));
          chk("A held data", ifa.dump_data, qa[0].data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_pend_b) begin
        chk("B done pulse", {31'b0, ifb.dump_done}, 32'd1);
        done_pend_b = 0;
      end else begin
        chk("B done idle", {31'b0, ifb.dump_done}, 32'd0);
      end
      if (ifb.dump_valid) begin
        if (qb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL B unexpected beat: got addr %0d want none",
                   ifb.dump_addr);
        end else if (ifb.dump_ready) begin
          beat_t e;
          e = qb.pop_front();
          chk("B beat addr", 32'(ifb.dump_addr), 32'(e.addr));
          chk("B beat data", 32'(ifb.dump_data), e.data);
          if (e.last) done_pend_b = 1;
        end else begin
          chk("B held addr", 32'(ifb.dump_addr), 32'(qb[0].addr));
          chk("B held data", 32'(ifb.dump_data), qb[0].data);
        end
      end
    end
  end

  task automatic wr_a(input int a, input logic [31:0] d);
    ifa.we = 1'b1;
    ifa.wa = 5'(a);
    ifa.wd = d;
    tick();
    ifa.we = 1'b0;
    if (a != 0) ma[a] = d;
  endtask

  task automatic wr_b(input int a, input logic [15:0] d);
    ifb.we = 1'b1;
    ifb.wa = 3'(a);
    ifb.wd = d;
    tick();
    ifb.we = 1'b0;
    mb[a] = d;
  endtask

  task automatic wr_c(input int a, input logic [7:0] d);
    ifc.we = 1'b1;
    ifc.wa = 3'(a);
    ifc.wd = d;
    tick();
    ifc.we = 1'b0;
    if (a < 5) mc[a] = d;
  endtask

  function automatic logic [7:0] exp_c(input int a);
    return (a < 5) ? mc[a] : 8'h00;
  endfunction

  task automatic push_a_model();
    for (int i = 0; i < 32; i++)
      qa.push_back('{addr: i, data: ma[i], last: (i == 31)});
  endtask

  task automatic start_a();
    ifa.dump_start = 1'b1;
    tick();
    ifa.dump_start = 1'b0;
  endtask

  task automatic drain_a(input string nm);
    int k = 0;
    while ((qa.size() != 0 || done_pend_a) && k < 400) begin
      tick();
      k++;
    end
    chk(nm, {31'b0, k < 400}, 32'd1);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 8; i++) mb[i] = '0;
    for (int i = 0; i < 5; i++) mc[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int k;
    ifa.we = 0; ifa.wa = 0; ifa.wd = 0; ifa.ra1 = 0; ifa.ra2 = 0;
    ifa.dump_start = 0; ifa.dump_ready = 0;
    ifb.we = 0; ifb.wa = 0; ifb.wd = 0; ifb.ra1 = 0; ifb.ra2 = 0;
    ifb.dump_start = 0; ifb.dump_ready = 0;
    ifc.we = 0; ifc.wa = 0; ifc.wd = 0; ifc.ra1 = 0; ifc.ra2 = 0;
    ifc.dump_start = 0; ifc.dump_ready = 0;
    clear_models();

    repeat (3) tick();
    chk("rst valid", {31'b0, ifa.dump_valid}, 32'd0);
    chk("rst busy", {31'b0, ifa.dump_busy}, 32'd0);
    chk("rst done", {31'b0, ifa.dump_done}, 32'd0);
    chk("rst addr", 32'(ifa.dump_addr), 32'd0);
    chk("rst data", ifa.dump_data, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) begin
      ifa.ra1 = 5'(i);
      ifa.ra2 = 5'(31 - i);
      #1;
      chk("A rd1 after reset", ifa.rd1, ma[i]);
      chk("A rd2 after reset", ifa.rd2, ma[31 - i]);
    end
    tick();

    ifa.we = 1'b1; ifa.wa = 5'd5; ifa.wd = 32'hDEADBEEF;
    ifa.ra1 = 5'd5;
    #1;
    chk("A no bypass", ifa.rd1, ma[5]);
    tick();
    ifa.we = 1'b0;
    ma[5] = 32'hDEADBEEF;
    chk("A rd r5 next", ifa.rd1, ma[5]);

    wr_a(0, 32'h12345678);
    ifa.ra1 = 5'd0;
    #1;
    chk("A r0 hardwired", ifa.rd1, ma[0]);

    for (int i = 0; i < 32; i++) wr_a(i, 32'(i) * 32'h11111111);
    push_a_model();
    ifa.dump_ready = 1'b1;
    start_a();
    chk("A start valid", {31'b0, ifa.dump_valid}, 32'd1);
    chk("A start addr", 32'(ifa.dump_addr), 32'd0);
    k = 0;
    while (!ifa.dump_done && k < 100) begin
      tick();
      k++;
    end
    chk("A scan cycles", 32'(k), 32'd32);
    ifa.dump_start = 1'b1;
    tick();
    ifa.dump_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("A start in DONE ignored", {31'b0, ifa.dump_valid}, 32'd0);
    end

    for (int i = 0; i < 32; i++)
      qa.push_back('{addr: i, data: (i == 3) ? 32'hA5A5A5A5 : ma[i],
                     last: (i == 31)});
    start_a();
    tick();
    tick();
    ifa.we = 1'b1; ifa.wa = 5'd3; ifa.wd = 32'hA5A5A5A5;
    tick();
    ifa.we = 1'b0;
    ma[3] = 32'hA5A5A5A5;
    drain_a("A forward drain");
    tick();

    push_a_model();
    start_a();
    repeat (3) tick();
    ifa.dump_ready = 1'b0;
    chk("A stall addr", 32'(ifa.dump_addr), 32'd3);
    ifa.we = 1'b1; ifa.wa = 5'd3; ifa.wd = 32'h5A5A5A5A;
    tick();
    ifa.we = 1'b0;
    ma[3] = 32'h5A5A5A5A;
    repeat (3) tick();
    ifa.dump_ready = 1'b1;
    drain_a("A stall drain");
    ifa.ra1 = 5'd3;
    #1;
    chk("A r3 after stall", ifa.rd1, ma[3]);
    tick();

    for (int i = 0; i < 20; i++)
      wr_b($urandom_range(0, 7), 16'($urandom));
    wr_b(0, 16'hBEEF);
    ifb.ra1 = 3'd0;
    #1;
    chk("B r0 writable", 32'(ifb.rd1), 32'(mb[0]));
    for (int i = 0; i < 8; i++)
      qb.push_back('{addr: i, data: 32'(mb[i]), last: (i == 7)});
    ifb.dump_ready = 1'($urandom_range(0, 1));
    ifb.dump_start = 1'b1;
    tick();
    k = 0;
    while ((qb.size() != 0 || done_pend_b) && k < 500) begin
      ifb.dump_ready = 1'($urandom_range(0, 1));
      ifb.dump_start = ifb.dump_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      k++;
    end
    chk("B drain", {31'b0, k < 500}, 32'd1);
    ifb.dump_start = 1'b0;
    ifb.dump_ready = 1'b1;
    repeat (4) tick();
    chk("B no restart", {31'b0, ifb.dump_valid}, 32'd0);

    for (int i = 0; i < 8; i++) wr_c(i, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      ifc.ra1 = 3'(i);
      ifc.ra2 = 3'(7 - i);
      #1;
      chk("C rd1 range", 32'(ifc.rd1), 32'(exp_c(i)));
      chk("C rd2 range", 32'(ifc.rd2), 32'(exp_c(7 - i)));
    end
    tick();

    push_a_model();
    start_a();
    k = 0;
    while (ifa.dump_addr != 5'd10 && k < 50) begin
      tick();
      k++;
    end
    chk("A reach beat 10", {31'b0, k < 50}, 32'd1);
    rst_n = 1'b0;
    ifa.ra1 = 5'd5;
    #1;
    qa.delete();
    done_pend_a = 0;
    done_pend_b = 0;
    clear_models();
    chk("A rst valid", {31'b0, ifa.dump_valid}, 32'd0);
    chk("A rst busy", {31'b0, ifa.dump_busy}, 32'd0);
    chk("A rst done", {31'b0, ifa.dump_done}, 32'd0);
    chk("A rst addr", 32'(ifa.dump_addr), 32'd0);
    chk("A rst data", ifa.dump_data, 32'd0);
    chk("A rst r5", ifa.rd1, ma[5]);
    tick();
    tick();
    rst_n = 1'b1;
    ifb.ra1 = 3'd0;
    #1;
    chk("B rst r0", 32'(ifb.rd1), 32'(mb[0]));
    tick();

    push_a_model();
    start_a();
    drain_a("A post-reset drain");
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scan.md
# regfile_scan

Parametrised register file with an integrated hardware dump engine; successor to the fixed 32×32 datapath register file. Two combinational read ports and one write port serve the datapath. A sequential scan engine streams every register out over a valid/ready channel, replacing bench-side hierarchical peeking with a synthesizable debug path usable on silicon and in simulation.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 32, number of registers (≥2)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- AW (localparam), $clog2(DEPTH), address width

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  WIDTH  read data, combinational
- dump_start  in  1  request a full scan (sampled in IDLE only)
- dump_ready  in  1  consumer accepts current beat
- dump_valid  out  1  beat present on dump_addr/dump_data
- dump_addr  out  AW  register index of current beat
- dump_data  out  WIDTH  register value of current beat
- dump_busy  out  1  scan in progress (SCAN state)
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset: all registers cleared to 0; FSM to IDLE; dump_valid, dump_busy, dump_done, dump_addr, dump_data all 0.
- Write: on clk edge with we=1, reg[wa] <= wd; suppressed when ZERO_REG=1 and wa=0. wa ≥ DEPTH (non-power-of-2 DEPTH): write dropped.
- Read: rd = reg[ra], combinational, no write bypass (same-cycle write visible next cycle). ra ≥ DEPTH returns 0. ZERO_REG=1 and ra=0 returns 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: dump_start=1 -> load beat for addr 0, dump_valid<=1, go SCAN.
  - SCAN: dump_valid=1, dump_busy=1. On dump_valid&&dump_ready: if dump_addr=DEPTH-1 -> dump_valid<=0, go DONE; else dump_addr+1 and load next beat. Without ready, dump_addr/dump_data held stable.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
- dump_start while in SCAN or DONE ignored (no queueing).
- Beat capture: dump_data registered on the edge the beat is loaded, from the array with write forwarding: if we=1 and wa equals the address being loaded on that same edge (and write not suppressed), capture wd. Writes after capture do not alter a held beat.
- Datapath reads/writes are never stalled by a scan.

## Timing
- Start latency: dump_start sampled high at edge N -> first beat valid after edge N.
- Throughput: 1 beat/cycle with dump_ready held high; DEPTH beats in DEPTH consecutive cycles; dump_done high in the cycle after the final handshake.
- Minimum scan-to-scan: DEPTH + 2 cycles (SCAN beats + DONE + IDLE sample).
- Reset asserted mid-scan: immediately returns to IDLE with all dump outputs 0 and registers cleared; no done pulse.
- dump_ready may toggle arbitrarily; valid never drops before handshake.

## Structure
- Package regfile_pkg: state enum (IDLE, SCAN, DONE), default WIDTH/DEPTH constants.
- Sub-module regfile_dump_fsm: state, address counter, beat register, forwarding compare; top instantiates array and read muxes plus this FSM.
- Target 150–250 lines RTL total.

## Test plan
- Reset then read all addresses -> rd1/rd2 = 0; write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF, same cycle -> 0.
- ZERO_REG=1: write 0x12345678 to r0 -> rd1(r0)=0 and dump beat 0 data=0.
- Preload reg[i]=i*0x11111111 (DEPTH=32), start with ready=1 -> 32 beats addr 0..31 on consecutive cycles, data matches, dump_done one cycle after beat 31.
- Random ready toggling, DEPTH=8, WIDTH=16 -> beats held stable while stalled, 8 beats in order, no duplicates or drops; dump_start pulses mid-scan ignored.
- Write r3=0xA5A5A5A5 on the edge beat 3 loads -> beat 3 data=0xA5A5A5A5; write r3 while beat 3 stalled -> beat unchanged.
- Assert reset at beat 10 -> dump_valid/busy/done=0 immediately, registers 0; new start after reset produces a full clean scan.
